pipeline_fetch: RTL and testbench
=================================

Name: pipeline_fetch

Overview:
- Instruction fetch stage directly upstream of the fetch/decode pipeline latch.
- Owns the PC register and drives the instruction-memory request handshake.
- Buffers a returned instruction while decode is stalled.
- Applies branch/jump redirects and halt, and presents instr_fet/pc4_fet plus a valid flag to the fetch/decode latch.

Parameters:
PC_INIT, 32'h00000000, PC value loaded on reset; bits [1:0] must be 0

Ports:
CLK  input  1  clock, all state updates on rising edge
nRST  input  1  asynchronous active-high reset (asserted = 1)
iren  output  1  instruction memory read request
iaddr  output  32  instruction address, equals pc
ihit  input  1  memory returns valid iload this cycle
iload  input  32  instruction word from memory
fd_accept  input  1  fetch/decode latch captures this cycle (fd_state == PIPE_ENABLE)
redirect  input  1  branch/jump taken, load redirect_pc
redirect_pc  input  32  redirect target; bits [1:0] ignored, treated as 00
halt  input  1  stop fetching permanently until reset
instr_fet  output  32  instruction to fetch/decode latch; 0 when not valid
pc4_fet  output  32  pc + 4 of presented instruction
fet_valid  output  1  instr_fet holds a real instruction

Behaviour:
- Registers: pc[31:0], hold buffer buf[31:0], state in {FETCH, HOLD, HALTED}.
- Reset (nRST=1, async): pc=PC_INIT, buf=0, state=FETCH.
  - While reset is asserted: iren=0, fet_valid=0, instr_fet=0.
  - Reset mid-stall or mid-HOLD discards buf.
- Combinational outputs:
  - iaddr=pc.
  - pc4_fet=pc+4, mod 2^32; 0xFFFFFFFC wraps to 0x00000000.
- FETCH:
  - iren=1.
  - ihit=1: instr_fet=iload, fet_valid=1 (same-cycle pass-through).
  - ihit=0: instr_fet=0, fet_valid=0; pc unchanged.
  - ihit&fd_accept: pc<=pc+4, stay FETCH.
  - ihit&!fd_accept: buf<=iload, go HOLD.
- HOLD:
  - iren=0, instr_fet=buf, fet_valid=1; ihit ignored.
  - fd_accept: pc<=pc+4, go FETCH.
  - Otherwise stay HOLD, pc unchanged.
- HALTED:
  - iren=0, fet_valid=0, instr_fet=0; pc frozen.
  - Only reset exits.
- Priority at each edge: halt > redirect > normal transitions.
  - halt=1 from any state: next state HALTED; pc not updated; buf discarded.
  - redirect=1 (halt=0): pc<={redirect_pc[31:2],2'b00}, state FETCH, buf discarded.
  - In a redirect cycle, fet_valid=0 and instr_fet=0 combinationally, so the latch captures a NOP. pc4_fet still reports pc+4 of the squashed address.
  - ihit/fd_accept in the same cycle as redirect/halt are ignored.
- Latency:
  - Cache hit: instruction presented in the cycle iaddr is driven.
  - One instruction accepted per cycle maximum.
  - No instruction is lost or duplicated across stalls.

Test Plan:
- Reset release, ihit=1, fd_accept=1 for 4 cycles, iload=A,B,C,D -> iaddr 0,4,8,C; pc4_fet 4,8,C,10; fet_valid=1 each cycle.
- ihit=0 for 3 cycles then 1 with fd_accept=1 -> iren=1 throughout; fet_valid=0 for 3 cycles; pc stays 0 until hit, then 4.
- Hit on 0x8C01_0004 with fd_accept=0 for 2 cycles then 1 -> HOLD: iren=0, instr_fet=0x8C01_0004 held; pc advances only on the accept edge; ihit toggling during HOLD has no effect.
- redirect=1, redirect_pc=0x0000_0103 while in HOLD -> fet_valid=0 that cycle; next cycle iaddr=0x0000_0100, state FETCH, buffered instruction never presented.
- halt=1 and redirect=1 in the same cycle -> HALTED: iren=0, fet_valid=0, pc unchanged; stays halted until nRST pulses, after which iaddr=PC_INIT.
- PC_INIT=0xFFFF_FFFC, hit+accept -> pc4_fet=0x0000_0000, next iaddr=0x0000_0000.

Source files
------------

// File: rtl/pipeline_fetch.sv
// ---------------------------------------------------------------------------
// pipeline_fetch
//    Instruction fetch stage feeding the fetch/decode pipeline latch. It owns
//    the PC, issues instruction-memory read requests and buffers a returned
//    instruction while decode is stalled. It also applies branch/jump
//    redirects and a sticky halt.
//
// Ports:
//    CLK          clock, all state updates on the rising edge
//    nRST         asynchronous reset, active high (asserted = 1)
//    iren         instruction memory read request
//    iaddr        instruction address (the current pc)
//    ihit         memory returns a valid iload this cycle
//    iload        instruction word from memory
//    fd_accept    fetch/decode latch captures this cycle
//    redirect     branch/jump taken, load redirect_pc
//    redirect_pc  redirect target, low two bits forced to zero
//    halt         stop fetching until the next reset
//    instr_fet    instruction presented to the latch, 0 when not valid
//    pc4_fet      pc + 4 of the presented instruction
//    fet_valid    instr_fet holds a real instruction
// ---------------------------------------------------------------------------
module pipeline_fetch #(
   parameter logic [31:0] PC_INIT = 32'h0000_0000
) (
   input  logic        CLK,
   input  logic        nRST,
   output logic        iren,
   output logic [31:0] iaddr,
   input  logic        ihit,
   input  logic [31:0] iload,
   input  logic        fd_accept,
   input  logic        redirect,
   input  logic [31:0] redirect_pc,
   input  logic        halt,
   output logic [31:0] instr_fet,
   output logic [31:0] pc4_fet,
   output logic        fet_valid
);

   typedef enum logic [1:0] {
      FETCH  = 2'd0,
      HOLD   = 2'd1,
      HALTED = 2'd2
   } fetch_state_t;

   fetch_state_t state;
   fetch_state_t state_next;
   logic [31:0]  pc;
   logic [31:0]  pc_next;
   logic [31:0]  hold_buf;
   logic [31:0]  hold_buf_next;
   logic [31:0]  pc_plus4;

   assign pc_plus4 = pc + 32'd4;
   assign iaddr    = pc;
   assign pc4_fet  = pc_plus4;

   // State, PC and hold buffer registers; reset discards any buffered word.
   always_ff @(posedge CLK or posedge nRST) begin
      if (nRST) begin
         state    <= FETCH;
         pc       <= PC_INIT;
         hold_buf <= 32'd0;
      end else begin
         state    <= state_next;
         pc       <= pc_next;
         hold_buf <= hold_buf_next;
      end
   end

   // Next-state and output logic. Normal FETCH/HOLD behaviour is worked out
   // first, then halt and redirect override it. Halt is checked first
   // because it wins over redirect. Both squash whatever would have been
   // presented, so the latch captures a NOP and nothing is issued twice.
   // Once HALTED, redirects are ignored because only reset may resume
   // fetching.
   always_comb begin
      state_next    = state;
      pc_next       = pc;
      hold_buf_next = hold_buf;
      iren          = 1'b0;
      instr_fet     = 32'd0;
      fet_valid     = 1'b0;

      case (state)
         FETCH: begin
            iren = 1'b1;
            if (ihit) begin
               instr_fet = iload;
               fet_valid = 1'b1;
               if (fd_accept) begin
                  pc_next = pc_plus4;
               end else begin
                  hold_buf_next = iload;
                  state_next    = HOLD;
               end
            end
         end
         HOLD: begin
            instr_fet = hold_buf;
            fet_valid = 1'b1;
            if (fd_accept) begin
               pc_next    = pc_plus4;
               state_next = FETCH;
            end
         end
         HALTED: begin
            state_next = HALTED;
         end
         default: begin
            state_next = FETCH;
         end
      endcase

      if (halt || (state == HALTED)) begin
         state_next    = HALTED;
         pc_next       = pc;
         hold_buf_next = 32'd0;
         instr_fet     = 32'd0;
         fet_valid     = 1'b0;
      end else if (redirect) begin
         state_next    = FETCH;
         pc_next       = {redirect_pc[31:2], 2'b00};
         hold_buf_next = 32'd0;
         instr_fet     = 32'd0;
         fet_valid     = 1'b0;
      end

      // Keep the memory and the latch quiet while reset is held.
      if (nRST) begin
         iren      = 1'b0;
         instr_fet = 32'd0;
         fet_valid = 1'b0;
      end
   end

endmodule

// File: tb/tb_pipeline_fetch.sv
// ---------------------------------------------------------------------------
// tb_pipeline_fetch
//    Self-checking bench for pipeline_fetch. It runs three kinds of test:
//    a directed vector table, hand-written reset and PC-wrap sequences, and
//    randomized traffic checked against a queue-based reference model.
// ---------------------------------------------------------------------------
module tb_pipeline_fetch;

   logic        CLK;
   logic        nRST;
   logic        iren;
   logic [31:0] iaddr;
   logic        ihit;
   logic [31:0] iload;
   logic        fd_accept;
   logic        redirect;
   logic [31:0] redirect_pc;
   logic        halt;
   logic [31:0] instr_fet;
   logic [31:0] pc4_fet;
   logic        fet_valid;

   logic        w_rst;
   logic        w_iren;
   logic [31:0] w_iaddr;
   logic [31:0] w_instr_fet;
   logic [31:0] w_pc4_fet;
   logic        w_fet_valid;

   int vectors;
   int miscompares;

   pipeline_fetch #(.PC_INIT(32'h0000_0000)) dut (
      .CLK(CLK), .nRST(nRST), .iren(iren), .iaddr(iaddr), .ihit(ihit),
      .iload(iload), .fd_accept(fd_accept), .redirect(redirect),
      .redirect_pc(redirect_pc), .halt(halt), .instr_fet(instr_fet),
      .pc4_fet(pc4_fet), .fet_valid(fet_valid)
   );

   // Second instance starting at the top of the address space for the wrap case.
   pipeline_fetch #(.PC_INIT(32'hFFFF_FFFC)) dut_wrap (
      .CLK(CLK), .nRST(w_rst), .iren(w_iren), .iaddr(w_iaddr), .ihit(1'b1),
      .iload(32'h1234_5678), .fd_accept(1'b1), .redirect(1'b0),
      .redirect_pc(32'd0), .halt(1'b0), .instr_fet(w_instr_fet),
      .pc4_fet(w_pc4_fet), .fet_valid(w_fet_valid)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   initial begin
      #2_000_000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   typedef struct {
      logic        ihit;
      logic [31:0] iload;
      logic        fd_accept;
      logic        redirect;
      logic [31:0] redirect_pc;
      logic        halt;
      logic        exp_iren;
      logic [31:0] exp_iaddr;
      logic        exp_valid;
      logic [31:0] exp_instr;
      logic [31:0] exp_pc4;
   } vec_t;

   vec_t table_vecs[20];

   // Reference model state: pc, a queue holding at most one stalled word,
   // and a sticky halted flag.
   logic [31:0] m_pc;
   logic [31:0] m_held[$];
   bit          m_halted;

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic applyStimulus(input logic h, input logic [31:0] ld, input logic acc,
                                input logic rd, input logic [31:0] rpc, input logic hl);
      ihit        = h;
      iload       = ld;
      fd_accept   = acc;
      redirect    = rd;
      redirect_pc = rpc;
      halt        = hl;
   endtask

   task automatic idleInputs();
      applyStimulus(1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 1'b0);
   endtask

   // Pulse reset away from the clock edges with idle inputs, so the first
   // edge after release does nothing.
   task automatic pulseReset();
      idleInputs();
      @(posedge CLK);
      #1 nRST = 1'b1;
      #2;
      applyStimulus(1'b1, 32'hAAAA_5555, 1'b1, 1'b0, 32'd0, 1'b0);
      #1;
      checkOutput("rst_iren", {31'd0, iren}, 32'd0);
      checkOutput("rst_valid", {31'd0, fet_valid}, 32'd0);
      checkOutput("rst_instr", instr_fet, 32'd0);
      idleInputs();
      @(negedge CLK);
      nRST = 1'b0;
      @(posedge CLK);
      #1;
      m_pc     = 32'h0000_0000;
      m_halted = 1'b0;
      m_held.delete();
   endtask

   task automatic modelCheck();
      logic        e_valid;
      logic [31:0] e_instr;
      logic        e_iren;
      e_iren  = !m_halted && (m_held.size() == 0);
      e_valid = !m_halted && !halt && !redirect && ((m_held.size() > 0) || ihit);
      e_instr = 32'd0;
      if (e_valid) e_instr = (m_held.size() > 0) ? m_held[0] : iload;
      checkOutput("rnd_iaddr", iaddr, m_pc);
      checkOutput("rnd_iren", {31'd0, iren}, {31'd0, e_iren});
      checkOutput("rnd_valid", {31'd0, fet_valid}, {31'd0, e_valid});
      checkOutput("rnd_instr", instr_fet, e_instr);
      checkOutput("rnd_pc4", pc4_fet, m_pc + 32'd4);
   endtask

   task automatic modelUpdate();
      if (m_halted) begin
      end else if (halt) begin
         m_halted = 1'b1;
         m_held.delete();
      end else if (redirect) begin
         m_pc = {redirect_pc[31:2], 2'b00};
         m_held.delete();
      end else if (m_held.size() > 0) begin
         if (fd_accept) begin
            m_pc = m_pc + 32'd4;
            m_held.delete();
         end
      end else if (ihit) begin
         if (fd_accept) m_pc = m_pc + 32'd4;
         else m_held.push_back(iload);
      end
   endtask

   initial begin
      vectors     = 0;
      miscompares = 0;
      nRST        = 1'b1;
      w_rst       = 1'b1;
      idleInputs();

      //                 ihit  iload          acc   rd    rpc            halt  iren  iaddr          vld   instr          pc4
      table_vecs[0]  = '{1'b1, 32'h0000_000A, 1'b1, 1'b0, 32'd0,         1'b0, 1'b1, 32'h0000_0000, 1'b1, 32'h0000_000A, 32'h0000_0004};
      table_vecs[1]  = '{1'b1, 32'h0000_000B, 1'b1, 1'b0, 32'd0,         1'b0, 1'b1, 32'h0000_0004, 1'b1, 32'h0000_000B, 32'h0000_0008};
      table_vecs[2]  = '{1'b1, 32'h0000_000C, 1'b1, 1'b0, 32'd0,         1'b0, 1'b1, 32'h0000_0008, 1'b1, 32'h0000_000C, 32'h0000_000C};
      table_vecs[3]  = '{1'b1, 32'h0000_000D, 1'b1, 1'b0, 32'd0,         1'b0, 1'b1, 32'h0000_000C, 1'b1, 32'h0000_000D, 32'h0000_0010};
      table_vecs[4]  = '{1'b0, 32'h1111_1111, 1'b1, 1'b0, 32'd0,         1'b0, 1'b1, 32'h0000_0010, 1'b0, 32'h0000_0000, 32'h0000_0014};
      table_vecs[5]  = '{1'b0, 32'h2222_2222, 1'b1, 1'b0, 32'd0,         1'b0, 1'b1, 32'h0000_0010, 1'b0, 32'h0000_0000, 32'h0000_0014};
      table_vecs[6]  = '{1'b0, 32'h3333_3333, 1'b0, 1'b0, 32'd0,         1'b0, 1'b1, 32'h0000_0010, 1'b0, 32'h0000_0000, 32'h0000_0014};
      table_vecs[7]  = '{1'b1, 32'h0000_000E, 1'b1, 1'b0, 32'd0,         1'b0, 1'b1, 32'h0000_0010, 1'b1, 32'h0000_000E, 32'h0000_0014};
      table_vecs[8]  = '{1'b1, 32'h8C01_0004, 1'b0, 1'b0, 32'd0,         1'b0, 1'b1, 32'h0000_0014, 1'b1, 32'h8C01_0004, 32'h0000_0018};
      table_vecs[9]  = '{1'b0, 32'h4444_4444, 1'b0, 1'b0, 32'd0,         1'b0, 1'b0, 32'h0000_0014, 1'b1, 32'h8C01_0004, 32'h0000_0018};
      table_vecs[10] = '{1'b1, 32'h0000_DEAD, 1'b0, 1'b0, 32'd0,         1'b0, 1'b0, 32'h0000_0014, 1'b1, 32'h8C01_0004, 32'h0000_0018};
      table_vecs[11] = '{1'b1, 32'h5555_5555, 1'b1, 1'b0, 32'd0,         1'b0, 1'b0, 32'h0000_0014, 1'b1, 32'h8C01_0004, 32'h0000_0018};
      table_vecs[12] = '{1'b1, 32'h0000_000F, 1'b0, 1'b0, 32'd0,         1'b0, 1'b1, 32'h0000_0018, 1'b1, 32'h0000_000F, 32'h0000_001C};
      table_vecs[13] = '{1'b1, 32'h6666_6666, 1'b1, 1'b1, 32'h0000_0103, 1'b0, 1'b0, 32'h0000_0018, 1'b0, 32'h0000_0000, 32'h0000_001C};
      table_vecs[14] = '{1'b1, 32'h0000_0123, 1'b1, 1'b0, 32'd0,         1'b0, 1'b1, 32'h0000_0100, 1'b1, 32'h0000_0123, 32'h0000_0104};
      table_vecs[15] = '{1'b1, 32'h7777_7777, 1'b1, 1'b1, 32'h0000_0204, 1'b0, 1'b1, 32'h0000_0104, 1'b0, 32'h0000_0000, 32'h0000_0108};
      table_vecs[16] = '{1'b1, 32'h8888_8888, 1'b1, 1'b1, 32'h0000_0300, 1'b1, 1'b1, 32'h0000_0204, 1'b0, 32'h0000_0000, 32'h0000_0208};
      table_vecs[17] = '{1'b1, 32'h9999_9999, 1'b1, 1'b0, 32'd0,         1'b0, 1'b0, 32'h0000_0204, 1'b0, 32'h0000_0000, 32'h0000_0208};
      table_vecs[18] = '{1'b1, 32'hAAAA_AAAA, 1'b1, 1'b1, 32'h0000_0400, 1'b0, 1'b0, 32'h0000_0204, 1'b0, 32'h0000_0000, 32'h0000_0208};
      table_vecs[19] = '{1'b0, 32'h0000_0000, 1'b0, 1'b0, 32'd0,         1'b0, 1'b0, 32'h0000_0204, 1'b0, 32'h0000_0000, 32'h0000_0208};

      // Reset held across a few edges, then released at a negedge.
      repeat (3) @(posedge CLK);
      #1;
      checkOutput("reset_iren", {31'd0, iren}, 32'd0);
      checkOutput("reset_valid", {31'd0, fet_valid}, 32'd0);
      checkOutput("reset_iaddr", iaddr, 32'h0000_0000);
      @(negedge CLK);
      nRST = 1'b0;
      @(posedge CLK);
      #1;

      // Directed vector table.
      for (int i = 0; i < 20; i++) begin
         applyStimulus(table_vecs[i].ihit, table_vecs[i].iload, table_vecs[i].fd_accept,
                       table_vecs[i].redirect, table_vecs[i].redirect_pc, table_vecs[i].halt);
         @(negedge CLK);
         checkOutput($sformatf("v%0d_iren", i), {31'd0, iren}, {31'd0, table_vecs[i].exp_iren});
         checkOutput($sformatf("v%0d_iaddr", i), iaddr, table_vecs[i].exp_iaddr);
         checkOutput($sformatf("v%0d_valid", i), {31'd0, fet_valid}, {31'd0, table_vecs[i].exp_valid});
         checkOutput($sformatf("v%0d_instr", i), instr_fet, table_vecs[i].exp_instr);
         checkOutput($sformatf("v%0d_pc4", i), pc4_fet, table_vecs[i].exp_pc4);
         @(posedge CLK);
         #1;
      end

      // Leaving HALTED takes a reset pulse, which brings iaddr back to PC_INIT.
      pulseReset();
      checkOutput("post_halt_iaddr", iaddr, 32'h0000_0000);
      checkOutput("post_halt_iren", {31'd0, iren}, 32'd1);

      // Reset in the middle of HOLD must discard the buffered word.
      applyStimulus(1'b1, 32'hBEEF_0001, 1'b0, 1'b0, 32'd0, 1'b0);
      @(posedge CLK);
      #1;
      checkOutput("hold_entry_iren", {31'd0, iren}, 32'd0);
      pulseReset();
      applyStimulus(1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 1'b0);
      #1;
      checkOutput("hold_rst_valid", {31'd0, fet_valid}, 32'd0);
      checkOutput("hold_rst_instr", instr_fet, 32'd0);

      // PC wrap at the top of the address space.
      @(negedge CLK);
      w_rst = 1'b0;
      #1;
      checkOutput("wrap_iaddr0", w_iaddr, 32'hFFFF_FFFC);
      checkOutput("wrap_pc4_0", w_pc4_fet, 32'h0000_0000);
      checkOutput("wrap_valid0", {31'd0, w_fet_valid}, 32'd1);
      @(posedge CLK);
      #1;
      checkOutput("wrap_iaddr1", w_iaddr, 32'h0000_0000);
      checkOutput("wrap_pc4_1", w_pc4_fet, 32'h0000_0004);

      // Randomized traffic against the reference model.
      pulseReset();
      for (int n = 0; n < 1500; n++) begin
         if (m_halted && ($urandom_range(0, 7) == 0)) begin
            pulseReset();
         end
         applyStimulus($urandom_range(0, 3) != 0, $urandom, $urandom_range(0, 2) != 0,
                       $urandom_range(0, 15) == 0, $urandom, $urandom_range(0, 63) == 0);
         @(negedge CLK);
         modelCheck();
         @(posedge CLK);
         modelUpdate();
         #1;
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
